avl_mem_responder: RTL

AVL_MEM_RESPONDER -- requirements
Module: avl_mem_responder

---
 rtl/avl_mem_responder.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/avl_mem_responder.sv
// avl_mem_responder
// -----------------
// Behavioural stand-in for an external-memory controller's Avalon-MM local
// interface. It emulates calibration (local_init_done after INIT_CYCLES),
// answers single-beat reads with a fixed latency of RD_LAT cycles, applies
// byte-enabled writes in the cycle they are accepted, and inserts a one-cycle
// back-pressure bubble after every STALL_EVERY accepted commands.
//
// Handshake: a command is accepted in a cycle where avl_ready = 1 and
// (avl_read_req | avl_write_req) = 1. While avl_ready = 0 the requester holds
// the command and nothing happens here. Read data comes back on
// avl_rdata_valid (one-cycle pulse) in acceptance order. No back-pressure
// exists on the response side.
//
// Ports
//   clk             : single clock, rising edge
//   rst             : synchronous active-high reset
//   avl_addr[26:0]  : word address, only [MEM_AW-1:0] decoded (aliases)
//   avl_read_req    : read command
//   avl_write_req   : write command
//   avl_wdata[31:0] : write data
//   avl_be[3:0]     : byte enables, bit i gates byte i
//   avl_size[2:0]   : burst length, only 1 supported
//   avl_burstbegin  : first-beat marker, accepted and ignored
//   avl_ready       : command can be accepted this cycle
//   avl_rdata[31:0] : read data, holds its value between pulses
//   avl_rdata_valid : avl_rdata valid this cycle
//   local_init_done : emulated calibration complete
//   proto_err       : sticky protocol-violation flag, cleared only by rst
//
// The memory array is deliberately outside reset so its contents survive rst.
// INIT_CYCLES is expected to be >= 1 and RD_LAT in 2..8.

module avl_mem_responder #(
  parameter int MEM_AW      = 10,
  parameter int RD_LAT      = 4,
  parameter int INIT_CYCLES = 64,
  parameter int STALL_EVERY = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [26:0] avl_addr,
  input  logic        avl_read_req,
  input  logic        avl_write_req,
  input  logic [31:0] avl_wdata,
  input  logic [3:0]  avl_be,
  input  logic [2:0]  avl_size,
  input  logic        avl_burstbegin,
  output logic        avl_ready,
  output logic [31:0] avl_rdata,
  output logic        avl_rdata_valid,
  output logic        local_init_done,
  output logic        proto_err
);

  // ---------------------------------------------------------------------------
  // Derived sizes
  // ---------------------------------------------------------------------------
  localparam int MEM_WORDS = 1 << MEM_AW;
  localparam int IW        = (INIT_CYCLES < 1) ? 1 : $clog2(INIT_CYCLES + 1);
  localparam int SW        = (STALL_EVERY < 2) ? 1 : $clog2(STALL_EVERY);
  // The read path is RD_LAT-1 pipeline stages plus the output register.
  localparam int PD        = RD_LAT - 1;

  localparam logic [IW-1:0] INIT_LAST  = IW'(INIT_CYCLES);
  localparam logic [SW-1:0] STALL_LAST = SW'((STALL_EVERY > 0) ? STALL_EVERY - 1 : 0);

  // ---------------------------------------------------------------------------
  // Emulated calibration
  // ---------------------------------------------------------------------------
  // The counter saturates at INIT_CYCLES; done is a pure decode of it so it
  // is high in exactly the cycle the count reaches INIT_CYCLES.
  logic [IW-1:0] init_cnt;
  logic          init_done;

  assign init_done = (init_cnt == INIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt <= '0;
    end else if (!init_done) begin
      init_cnt <= init_cnt + 1'b1;
    end
  end

  assign local_init_done = init_done;

  // ---------------------------------------------------------------------------
  // Command acceptance
  // ---------------------------------------------------------------------------
  logic              stall_q;
  logic [SW-1:0]     stall_cnt;
  logic              accept;
  logic              wr_acc;
  logic              rd_acc;
  logic              cmd_bad;
  logic [MEM_AW-1:0] mem_idx;

  assign avl_ready = init_done & ~stall_q;
  assign accept    = avl_ready & (avl_read_req | avl_write_req);
  // A simultaneous read+write keeps the write and drops the read.
  assign wr_acc    = accept & avl_write_req;
  assign rd_acc    = accept & avl_read_req & ~avl_write_req;
  assign cmd_bad   = accept & ((avl_read_req & avl_write_req) | (avl_size != 3'd1));
  assign mem_idx   = avl_addr[MEM_AW-1:0];

  // Upper address bits alias and the burst marker carries no information for
  // single-beat traffic; fold them into a sink so they are visibly consumed.
  logic unused_bits;
  assign unused_bits = ^{avl_addr[26:MEM_AW], avl_burstbegin};

  // ---------------------------------------------------------------------------
  // Stall generator: one bubble after every STALL_EVERY accepts
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      stall_q   <= 1'b0;
    end else begin
      stall_q <= 1'b0;
      if (STALL_EVERY > 0 && accept) begin
        if (stall_cnt == STALL_LAST) begin
          stall_cnt <= '0;
          stall_q   <= 1'b1;
        end else begin
          stall_cnt <= stall_cnt + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol error flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      proto_err <= 1'b0;
    end else if (cmd_bad) begin
      proto_err <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory array (not reset)
  // ---------------------------------------------------------------------------
  // Writes land at the accepting edge, so a read accepted in the following
  // cycle already sees the new data without any bypass logic.
  logic [31:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int b = 0; b < 4; b++) begin
        if (avl_be[b]) begin
          mem[mem_idx][8*b +: 8] <= avl_wdata[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline
  // ---------------------------------------------------------------------------
  // Stage 0 captures the addressed word at acceptance; the valid bits are
  // reset so in-flight reads are discarded on rst, the data bits need not be.
  logic [PD-1:0] pipe_vld;
  logic [31:0]   pipe_data [PD];

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= rd_acc;
      for (int i = 1; i < PD; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    pipe_data[0] <= mem[mem_idx];
    for (int i = 1; i < PD; i++) begin
      pipe_data[i] <= pipe_data[i-1];
    end
  end

  // Output register: rdata only loads on a valid beat so it holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      avl_rdata_valid <= 1'b0;
      avl_rdata       <= '0;
    end else begin
      avl_rdata_valid <= pipe_vld[PD-1];
      if (pipe_vld[PD-1]) begin
        avl_rdata <= pipe_data[PD-1];
      end
    end
  end

endmodule
